// File: rtl/song_pos_table.sv
// song_pos_table: run-time loadable table of per-channel song lengths.
// On a song select it walks the song rows sequentially, accumulating prefix
// sums for every channel in parallel, then presents each channel's start
// address, length and an address-space overflow flag.
module song_pos_table #(
  parameter int unsigned CHANNELS = 13,
  parameter int unsigned SONGS    = 4,
  parameter int unsigned SONG_W   = 2,
  parameter int unsigned CH_W     = 4,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned LEN_W    = 12,
  parameter logic [CHANNELS*SONGS*LEN_W-1:0] LEN_INIT = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       sel_valid,
  input  logic [SONG_W-1:0]          sel_song,
  output logic                       sel_ready,
  input  logic                       wr_en,
  input  logic [CH_W-1:0]            wr_chan,
  input  logic [SONG_W-1:0]          wr_song,
  input  logic [LEN_W-1:0]           wr_len,
  output logic                       pos_valid,
  output logic [CHANNELS*ADDR_W-1:0] pos_base,
  output logic [CHANNELS*LEN_W-1:0]  pos_len,
  output logic [CHANNELS-1:0]        overflow
);

  // idx must be able to reach SONGS itself (the out-of-range terminator)
  localparam int unsigned IDX_W = (SONGS < 1) ? 1 : $clog2(SONGS + 1);
  // sum is wide enough for acc + len without losing the carry
  localparam int unsigned SUM_W = ((LEN_W > ADDR_W) ? LEN_W : ADDR_W) + 1;
  localparam logic [SUM_W-1:0] ADDR_SPAN = SUM_W'(1) << ADDR_W;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  state_e                            state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [SONG_W-1:0]                 target_q, target_d;
  logic [CHANNELS-1:0][ADDR_W-1:0]   acc_q, acc_d;
  logic [CHANNELS-1:0]               sticky_q, sticky_d;
  logic [CHANNELS-1:0][ADDR_W-1:0]   base_q, base_d;
  logic [CHANNELS-1:0][LEN_W-1:0]    plen_q, plen_d;
  logic [CHANNELS-1:0]               ovf_q, ovf_d;
  logic                              valid_q, valid_d;
  logic [LEN_W-1:0]                  len_q [SONGS][CHANNELS];
  logic [LEN_W-1:0]                  len_d [SONGS][CHANNELS];

  logic                              wr_commit;
  logic                              at_end;
  logic [CHANNELS-1:0][LEN_W-1:0]    rd_len;
  logic [CHANNELS-1:0][SUM_W-1:0]    sum;

  assign sel_ready = (state_q == IDLE);
  assign wr_commit = wr_en && sel_ready
                     && (32'(wr_chan) < CHANNELS) && (32'(wr_song) < SONGS);
  assign at_end    = (32'(idx_q) == 32'(target_q)) || (32'(idx_q) == SONGS);

  assign pos_valid = valid_q;
  assign pos_base  = base_q;
  assign pos_len   = plen_q;
  assign overflow  = ovf_q;

  // Read the current row; idx == SONGS yields an all-zero row.
  always_comb begin
    rd_len = '0;
    for (int unsigned s = 0; s < SONGS; s++) begin
      if (32'(idx_q) == s) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          rd_len[c] = len_q[s][c];
        end
      end
    end
  end

  // Per-channel accumulator plus current row, carry kept above ADDR_W.
  always_comb begin
    sum = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      sum[c] = SUM_W'(acc_q[c]) + SUM_W'(rd_len[c]);
    end
  end

  // Length table next state: single-entry write while idle and in range.
  always_comb begin
    len_d = len_q;
    for (int unsigned s = 0; s < SONGS; s++) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (wr_commit && (32'(wr_song) == s) && (32'(wr_chan) == c)) begin
          len_d[s][c] = wr_len;
        end
      end
    end
  end

  // FSM next state and datapath: accept select, accumulate, publish result.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    target_d = target_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    base_d   = base_q;
    plen_d   = plen_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;

    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          target_d = sel_song;
          idx_d    = '0;
          acc_d    = '0;
          sticky_d = '0;
          valid_d  = 1'b0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (at_end) begin
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            base_d[c] = acc_q[c];
            plen_d[c] = rd_len[c];
            ovf_d[c]  = sticky_q[c] | (sum[c] > ADDR_SPAN);
          end
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          // Wrap modulo 2^ADDR_W, folding any carry into the sticky flag.
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            acc_d[c]    = sum[c][ADDR_W-1:0];
            sticky_d[c] = sticky_q[c] | (|sum[c][SUM_W-1:ADDR_W]);
          end
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      target_q <= '0;
      acc_q    <= '0;
      sticky_q <= '0;
      base_q   <= '0;
      plen_q   <= '0;
      ovf_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      base_q   <= base_d;
      plen_q   <= plen_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  // Length table, reloaded from LEN_INIT on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < SONGS; s++) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          len_q[s][c] <= LEN_INIT[(s*CHANNELS+c)*LEN_W +: LEN_W];
        end
      end
    end else begin
      len_q <= len_d;
    end
  end

endmodule

// File: tb/tb_song_pos_table.sv
// Self-checking bench for song_pos_table: directed scenarios plus randomized
// writes/selects checked against an exact-arithmetic reference model.
module tb_song_pos_table;

  localparam int CH = 13;
  localparam int SG = 4;
  localparam int AW = 16;
  localparam int LW = 16;
  localparam int SW = 3;
  localparam int CW = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              sel_valid;
  logic [SW-1:0]     sel_song;
  logic              sel_ready;
  logic              wr_en;
  logic [CW-1:0]     wr_chan;
  logic [SW-1:0]     wr_song;
  logic [LW-1:0]     wr_len;
  logic              pos_valid;
  logic [CH*AW-1:0]  pos_base;
  logic [CH*LW-1:0]  pos_len;
  logic [CH-1:0]     overflow;

  // Small three-song instance with a preloaded table
  logic              b_sel_valid;
  logic [1:0]        b_sel_song;
  logic              b_sel_ready;
  logic              b_wr_en;
  logic [0:0]        b_wr_chan;
  logic [1:0]        b_wr_song;
  logic [11:0]       b_wr_len;
  logic              b_pos_valid;
  logic [31:0]       b_pos_base;
  logic [23:0]       b_pos_len;
  logic [1:0]        b_overflow;

  int checks = 0;
  int errors = 0;
  int unsigned mlen [SG][CH];

  always #5 clock = ~clock;

  song_pos_table #(
    .CHANNELS(CH), .SONGS(SG), .SONG_W(SW), .CH_W(CW),
    .ADDR_W(AW), .LEN_W(LW), .LEN_INIT('0)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .sel_valid(sel_valid), .sel_song(sel_song), .sel_ready(sel_ready),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_song(wr_song), .wr_len(wr_len),
    .pos_valid(pos_valid), .pos_base(pos_base), .pos_len(pos_len),
    .overflow(overflow)
  );

  song_pos_table #(
    .CHANNELS(2), .SONGS(3), .SONG_W(2), .CH_W(1), .ADDR_W(16), .LEN_W(12),
    .LEN_INIT({12'd3, 12'd30, 12'd2, 12'd20, 12'd1, 12'd10})
  ) dut3 (
    .clock(clock), .reset_n(reset_n),
    .sel_valid(b_sel_valid), .sel_song(b_sel_song), .sel_ready(b_sel_ready),
    .wr_en(b_wr_en), .wr_chan(b_wr_chan), .wr_song(b_wr_song), .wr_len(b_wr_len),
    .pos_valid(b_pos_valid), .pos_base(b_pos_base), .pos_len(b_pos_len),
    .overflow(b_overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: exact sum of the lengths of all songs before t
  function automatic longint prefix(input int t, input int c);
    longint s = 0;
    int lim = (t < SG) ? t : SG;
    for (int k = 0; k < lim; k++) s += mlen[k][c];
    return s;
  endfunction

  function automatic longint song_len(input int t, input int c);
    return (t < SG) ? longint'(mlen[t][c]) : 0;
  endfunction

  task automatic model_write(input int wc, input int ws, input int wl);
    if (wc < CH && ws < SG) mlen[ws][wc] = wl;
  endtask

  task automatic check_all(input int t);
    for (int c = 0; c < CH; c++) begin
      longint pre = prefix(t, c);
      longint l   = song_len(t, c);
      // Any wrap during the prefix, or the song end passing 2^AW, overflows
      logic ov = (pre >= 65536) || (pre + l > 65536);
      check($sformatf("base ch%0d song%0d", c, t), pos_base[c*AW +: AW], pre % 65536);
      check($sformatf("len ch%0d song%0d", c, t), pos_len[c*LW +: LW], l);
      check($sformatf("ovf ch%0d song%0d", c, t), overflow[c], ov);
    end
  endtask

  // Entered and left at a negedge.
  task automatic do_write(input int wc, input int ws, input int wl);
    wr_en = 1'b1; wr_chan = CW'(wc); wr_song = SW'(ws); wr_len = LW'(wl);
    @(posedge clock);
    model_write(wc, ws, wl);
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  // wmode: 0 none, 1 write on the accepting edge, 2 write during ACCUM (dropped)
  task automatic do_select(input int t, input int wmode, input int wc, input int ws, input int wl);
    int n = 0;
    bit done = 0;
    int lat = ((t < SG) ? t : SG) + 1;
    sel_valid = 1'b1; sel_song = SW'(t);
    if (wmode == 1) begin
      wr_en = 1'b1; wr_chan = CW'(wc); wr_song = SW'(ws); wr_len = LW'(wl);
    end
    @(posedge clock);
    if (wmode == 1) model_write(wc, ws, wl);
    @(negedge clock);
    sel_valid = 1'b0; wr_en = 1'b0;
    check("ready_low_after_accept", sel_ready, 0);
    check("valid_low_after_accept", pos_valid, 0);
    if (wmode == 2) begin
      wr_en = 1'b1; wr_chan = CW'(wc); wr_song = SW'(ws); wr_len = LW'(wl);
    end
    while (!done && n < 16) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      wr_en = 1'b0;
      check($sformatf("ready cycle%0d song%0d", n, t), sel_ready, (n >= lat));
      if (pos_valid) done = 1;
    end
    check("select_timeout", done, 1);
    check($sformatf("latency song%0d", t), n, lat);
    check_all(t);
  endtask

  task automatic do_select3(input int t, input int lat, input int b0, input int l0,
                            input int b1, input int l1);
    int n = 0;
    bit done = 0;
    b_sel_valid = 1'b1; b_sel_song = 2'(t);
    @(posedge clock);
    @(negedge clock);
    b_sel_valid = 1'b0;
    while (!done && n < 16) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (b_pos_valid) done = 1;
    end
    check("s3_timeout", done, 1);
    check($sformatf("s3 latency song%0d", t), n, lat);
    check("s3 ready", b_sel_ready, 1);
    check($sformatf("s3 base0 song%0d", t), b_pos_base[15:0], b0);
    check($sformatf("s3 len0 song%0d", t), b_pos_len[11:0], l0);
    check($sformatf("s3 base1 song%0d", t), b_pos_base[31:16], b1);
    check($sformatf("s3 len1 song%0d", t), b_pos_len[23:12], l1);
    check("s3 ovf", b_overflow, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    sel_valid = 1'b0; sel_song = '0; wr_en = 1'b0; wr_chan = '0; wr_song = '0; wr_len = '0;
    b_sel_valid = 1'b0; b_sel_song = '0; b_wr_en = 1'b0; b_wr_chan = '0; b_wr_song = '0; b_wr_len = '0;
    for (int s = 0; s < SG; s++) for (int c = 0; c < CH; c++) mlen[s][c] = 0;
    repeat (3) @(negedge clock);

    check("rst sel_ready", sel_ready, 1);
    check("rst pos_valid", pos_valid, 0);
    check("rst pos_base", |pos_base, 0);
    check("rst pos_len", |pos_len, 0);
    check("rst overflow", overflow, 0);
    check("rst s3 ready", b_sel_ready, 1);
    reset_n = 1'b1;
    @(negedge clock);

    // Empty table
    do_select(2, 0, 0, 0, 0);

    // Basic prefix sums
    do_write(0, 0, 526); do_write(0, 1, 291); do_write(0, 2, 81); do_write(0, 3, 100);
    do_write(9, 0, 538); do_write(9, 1, 529); do_write(9, 2, 411); do_write(9, 3, 7);
    do_select(2, 0, 0, 0, 0);
    check("ch0 base 817", pos_base[15:0], 817);
    check("ch0 len 81", pos_len[15:0], 81);
    check("ch9 base 1067", pos_base[9*AW +: AW], 1067);
    check("ch9 len 411", pos_len[9*LW +: LW], 411);

    // Wrap and overflow edges
    do_write(1, 0, 40000); do_write(1, 1, 30000); do_write(1, 2, 5); do_write(1, 3, 0);
    do_write(2, 0, 65000); do_write(2, 1, 536);
    do_write(3, 0, 65000); do_write(3, 1, 537);
    do_select(2, 0, 0, 0, 0);
    check("ch1 base 4464", pos_base[AW +: AW], 4464);
    check("ch1 overflow", overflow[1], 1);
    check("ch0 no overflow", overflow[0], 0);
    do_select(1, 0, 0, 0, 0);
    check("ch2 ends exactly at 2^16", overflow[2], 0);
    check("ch3 ends past 2^16", overflow[3], 1);

    // Write on the accepting edge is used; write during ACCUM is dropped
    do_select(1, 1, 0, 0, 50);
    check("same-edge write base", pos_base[15:0], 50);
    do_select(3, 2, 0, 0, 77);
    do_select(1, 0, 0, 0, 0);
    check("accum write dropped", pos_base[15:0], 50);

    // Out-of-range write indices and select targets
    do_write(13, 0, 1234); do_write(15, 1, 999); do_write(0, 5, 4321);
    do_select(4, 0, 0, 0, 0);
    do_select(7, 0, 0, 0, 0);

    // Randomized writes and back-to-back selects
    for (int i = 0; i < 30; i++) begin
      int nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) begin
        int wc = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 15) : $urandom_range(0, 12);
        int ws = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
        int wl = $urandom_range(0, 1) ? $urandom_range(0, 65535) : $urandom_range(0, 999);
        do_write(wc, ws, wl);
      end
      do_select($urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 15),
                $urandom_range(0, 7), $urandom_range(0, 65535));
    end

    // Three-song instance, including an out-of-range song write
    b_wr_en = 1'b1; b_wr_chan = 1'b0; b_wr_song = 2'd3; b_wr_len = 12'd99;
    @(posedge clock);
    @(negedge clock);
    b_wr_en = 1'b0;
    do_select3(3, 4, 60, 0, 6, 0);
    do_select3(1, 2, 10, 20, 1, 2);
    do_select3(0, 1, 0, 10, 0, 1);
    do_select3(2, 3, 30, 30, 3, 3);

    // Reset two cycles into a song-3 calculation
    do_write(5, 0, 321);
    do_select(1, 0, 0, 0, 0);
    sel_valid = 1'b1; sel_song = 3'd3;
    @(posedge clock);
    @(negedge clock);
    sel_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midrst sel_ready", sel_ready, 1);
    check("midrst pos_valid", pos_valid, 0);
    check("midrst pos_base", |pos_base, 0);
    check("midrst pos_len", |pos_len, 0);
    check("midrst overflow", overflow, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int s = 0; s < SG; s++) for (int c = 0; c < CH; c++) mlen[s][c] = 0;
    @(negedge clock);
    do_select(3, 0, 0, 0, 0);
    do_select3(3, 4, 60, 0, 6, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/song_pos_table.md
# song_pos_table

Parametrised, run-time loadable song-offset table for the multi-channel synthesiser. It replaces the fixed per-channel position ROMs. The table holds the note-memory length of every song on every channel. When a song is selected, it accumulates the prefix sums sequentially and presents, for every channel at once, the start address and length of that song in the channel's note memory. It sits between the song/level selector and the per-channel note sequencers; a completion flag tells the sequencers when the addresses are valid.

## Interface
- CHANNELS, 13, number of voice channels served in parallel
- SONGS, 4, number of songs per channel
- SONG_W, 2, width of song index (≥ clog2(SONGS+1) not required; out-of-range indices handled)
- CH_W, 4, width of channel index for the write port
- ADDR_W, 16, note-memory address width
- LEN_W, 12, per-song length width
- LEN_INIT, 0, flat vector CHANNELS*SONGS*LEN_W; entry (s,c) at bits [(s*CHANNELS+c)*LEN_W +: LEN_W]

- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- sel_valid  in  1  song-select request
- sel_song  in  SONG_W  requested song index
- sel_ready  out  1  block idle, select and writes accepted
- wr_en  in  1  length-table write strobe
- wr_chan  in  CH_W  channel of written entry
- wr_song  in  SONG_W  song of written entry
- wr_len  in  LEN_W  new length value
- pos_valid  out  1  pos_base/pos_len/overflow valid for last accepted select
- pos_base  out  CHANNELS*ADDR_W  per-channel start address, channel c at [c*ADDR_W +: ADDR_W]
- pos_len  out  CHANNELS*LEN_W  per-channel song length
- overflow  out  CHANNELS  per-channel flag: base+len exceeds 2^ADDR_W

## Operation
- The length table is a register array. Reset loads it from LEN_INIT.
- Writes:
  - A write is committed when wr_en && sel_ready.
  - A write with wr_en while sel_ready is low is dropped.
  - A write with wr_chan ≥ CHANNELS or wr_song ≥ SONGS is dropped.
- FSM has two states, IDLE and ACCUM.
- IDLE:
  - sel_ready = 1.
  - A select is accepted when sel_valid is high. On the accepting edge: latch target = sel_song, idx = 0, all accumulators = 0, sticky carries = 0, pos_valid = 0, go to ACCUM.
- ACCUM:
  - sel_ready = 0.
  - Each edge, all channels are processed in parallel.
  - If idx == target or idx == SONGS: pos_base[c] = acc[c][ADDR_W-1:0]; pos_len[c] = (idx == SONGS) ? 0 : len[idx][c]; overflow[c] = sticky[c] | (acc[c] + pos_len[c] > 2^ADDR_W); pos_valid = 1; go to IDLE.
  - Otherwise: acc[c] += len[idx][c]. The accumulator is ADDR_W+1 bits; bit ADDR_W ORs into sticky[c] and is then cleared (wrap modulo 2^ADDR_W). Then idx++.
- Out-of-range target (≥ SONGS): result is base = total of all songs, len = 0.
- Outputs hold their values until the next accepted select. pos_valid drops on that accepting edge.
- Simultaneous write and select on the same edge: both are committed. The accumulation uses the new value.

## Timing
- Reset values:
  - sel_ready = 1, pos_valid = 0, pos_base = 0, pos_len = 0, overflow = 0.
  - State IDLE; table = LEN_INIT.
- Reset asserted mid-ACCUM aborts the calculation immediately. All outputs and the table return to reset values.
- Select accepted at edge E0 → pos_valid rises at edge E(t+1), where t = min(sel_song, SONGS).
- sel_ready is low from E0 through E(t+1) and high again after E(t+1).
- Back-to-back selects are possible: a new select can be accepted on the edge after E(t+1).
- The write port is single-cycle, with no latency to the next calculation.

## Test plan
- Reset with LEN_INIT = 0, then select song 2 → pos_valid at E3, all pos_base = 0, pos_len = 0, overflow = 0.
- Write ch0 lengths 526, 291, 81, 100 and ch9 lengths 538, 529, 411, 7; select song 2:
  - ch0 base 817, len 81; ch9 base 1067, len 411.
  - sel_ready low E0..E3.
- Write ch1 lengths 40000, 30000, 5, 0; select song 2 → ch1 base 4464, len 5, overflow[1] = 1; other channels overflow 0.
- SONGS = 3 instance, ch0 lengths 10, 20, 30, sel_song = 3 → pos_valid at E4, base 60, len 0.
- Write ch0 song0 = 50 asserted with select song 1 on the same edge → base 50. A write during ACCUM is dropped and the table is unchanged on a reread.
- Assert reset_n = 0 two cycles into a song-3 calculation → sel_ready = 1, pos_valid = 0 and all outputs 0 immediately; the table is back to LEN_INIT.
